zone_sequencer: RTL and testbench
=================================

ZONE_SEQUENCER -- requirements
Module: zone_sequencer

Interface
REQ-001 Parameters SHALL be: ZONE_TICKS, default 10, watering duration per zone in ticks (legal 1..255); GAP_TICKS, default 1, all-valves-off pause between zones in ticks (legal 1..255).
REQ-002 Ports, clock and reset first:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  begin one watering cycle.
- stop  in  1  abort the current cycle.
- rain  in  1  global inhibit.
- tick  in  1  one-clk timebase enable.
- soil_dry  in  6  bit k-1 high = zone k needs water.
- sel  out  3  zone select to the downstream 1-to-7 valve demux.
- valve_en  out  1  demux data input.
- busy  out  1  cycle in progress.
- done  out  1  one-clk end-of-cycle pulse.

Function
REQ-003 All outputs SHALL be registered; zone index SHALL range 1..6; sel=0 drives no valve.
REQ-004 FSM states SHALL be IDLE, SCAN, WATER, GAP, DONE.
REQ-005 IDLE: sel=0, valve_en=0, busy=0; start=1 and rain=0 -> SCAN with zone=1; start with rain=1 SHALL be ignored.
REQ-006 SCAN SHALL evaluate one zone per clk: soil_dry[zone-1]=1 -> WATER with timer=0; otherwise zone=6 -> DONE, else zone+1 and stay in SCAN.
REQ-007 WATER: sel=zone, valve_en=1; timer SHALL increment only on tick; tick with timer=ZONE_TICKS-1 -> GAP with timer=0.
REQ-008 GAP: sel=0, valve_en=0; tick with timer=GAP_TICKS-1 -> DONE if zone=6, else SCAN with zone+1.
REQ-009 DONE SHALL last exactly one clk with done=1, then -> IDLE; done SHALL be 0 in every other state.
REQ-010 busy SHALL be 1 in SCAN, WATER, GAP and DONE.
REQ-011 stop=1 or rain=1 in SCAN, WATER or GAP -> DONE on the next edge; valve_en SHALL be 0 from that edge onward.
REQ-012 stop takes priority over tick when both are high on the same clk; start while busy=1 SHALL be ignored.
REQ-013 At most one valve SHALL be open at any time; sel SHALL change only while valve_en=0 or on the edge that sets it to 0.
REQ-014 The timer SHALL be 8 bits wide and SHALL never wrap within a zone.

Reset
REQ-015 With rst_n=0 at a clk edge: state=IDLE, zone=1, timer=0, sel=0, valve_en=0, busy=0, done=0.
REQ-016 Reset asserted mid-WATER SHALL close the valve on that same edge, and SHALL NOT produce a done pulse.

Configuration
REQ-017 With ZONE_SEQ_MANUAL_EN defined, ports manual_req (in, 1) and manual_zone (in, 3) SHALL exist. In IDLE with rain=0, manual_req=1 and manual_zone in 1..6 -> WATER for that zone only, regardless of soil_dry, then DONE with no GAP. manual_zone values 0 or 7 SHALL be ignored. start SHALL have priority over manual_req.
REQ-018 Without ZONE_SEQ_MANUAL_EN, those ports and their logic SHALL be absent, and behaviour SHALL be exactly REQ-005..REQ-014.

Structure
REQ-019 Package rega_pkg SHALL hold the state enum, NUM_ZONES=6, SEL_W=3 and ZONE_W=6.
REQ-020 One sub-module, tick_timer, SHALL provide the 8-bit tick counter with clear and terminal-count compare; the FSM SHALL stay in zone_sequencer.

Verification (ZONE_TICKS=3, GAP_TICKS=1, tick every 4 clk)
REQ-021 Full cycle: soil_dry=6'b111111, start pulse -> sel steps 1..6, each held with valve_en=1 for 3 ticks and separated by a 1-tick gap; then done for 1 clk and busy=0.
REQ-022 Skipping: soil_dry=6'b010010 -> only sel=2 and sel=5 are watered; zones 1, 3, 4 and 6 spend 1 clk each in SCAN; done fires once.
REQ-023 Rain abort: rain=1 during zone 3 WATER -> valve_en=0 at the next edge, done pulses once, start is ignored while rain=1.
REQ-024 Reset mid-operation: rst_n=0 for 1 clk during zone 2 WATER -> all outputs 0 after that edge, and no done pulse.
REQ-025 Edge cases: soil_dry=0 with start -> 6 SCAN clk, then done with valve_en never 1. Then start held high during busy -> exactly one cycle runs.
REQ-026 With ZONE_SEQ_MANUAL_EN: manual_zone=4, manual_req=1 -> sel=4 for 3 ticks, then done. manual_zone=7 -> no response.

Source files
------------

// File: rtl/rega_pkg.sv
// Shared types and constants for the irrigation zone sequencer.
// State encoding, zone count and bus widths live here.
package rega_pkg;

    localparam int NUM_ZONES = 6;
    localparam int SEL_W     = 3;
    localparam int ZONE_W    = 6;

    localparam logic [SEL_W-1:0] FIRST_ZONE = 3'd1;
    localparam logic [SEL_W-1:0] LAST_ZONE  = 3'd6;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        WATER,
        GAP,
        DONE
    } state_t;

    // True for a zone number that maps to a real valve
    function automatic logic zone_ok(
        input logic [SEL_W-1:0] z
    );
        return (z >= FIRST_ZONE) && (z <= LAST_ZONE);
    endfunction

endpackage

// File: rtl/tick_timer.sv
// 8-bit tick counter with synchronous clear and terminal-count compare.
// hit is high while the count equals the supplied terminal value.
module tick_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] tc,
    output logic       hit
);

    logic [7:0] cnt;

    // Count enabled ticks; clear wins over counting
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign hit = (cnt == tc);

endmodule

// File: rtl/zone_sequencer.sv
// Six-zone irrigation sequencer driving a 1-to-7 valve demux.
// Optional manual single-zone watering: define ZONE_SEQ_MANUAL_EN.
module zone_sequencer
    import rega_pkg::*;
#(
    parameter int ZONE_TICKS = 10,
    parameter int GAP_TICKS  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              rain,
    input  logic              tick,
    input  logic [ZONE_W-1:0] soil_dry,
`ifdef ZONE_SEQ_MANUAL_EN
    input  logic              manual_req,
    input  logic [SEL_W-1:0]  manual_zone,
`endif
    output logic [SEL_W-1:0]  sel,
    output logic              valve_en,
    output logic              busy,
    output logic              done
);

    localparam logic [7:0] ZONE_TC = 8'(ZONE_TICKS - 1);
    localparam logic [7:0] GAP_TC  = 8'(GAP_TICKS - 1);

    state_t           state;
    state_t           state_n;
    logic [SEL_W-1:0] zone;
    logic [SEL_W-1:0] zone_n;

`ifdef ZONE_SEQ_MANUAL_EN
    logic             man;
    logic             man_n;
`endif

    logic [SEL_W-1:0] sel_d;
    logic             ven_d;
    logic             busy_d;
    logic             done_d;

    logic             t_clr;
    logic             t_hit;
    logic [7:0]       t_tc;
    logic             abort;
    logic             expire;

    assign abort  = stop | rain;
    assign expire = tick & t_hit;
    assign t_tc   = (state == WATER) ? ZONE_TC : GAP_TC;

    // Restart the timer on every state change and outside timed states
    assign t_clr  = (state_n != state)
                  | ((state != WATER) & (state != GAP));

    tick_timer u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (t_clr),
        .en    (tick),
        .tc    (t_tc),
        .hit   (t_hit)
    );

    // State, zone and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            zone     <= FIRST_ZONE;
            sel      <= '0;
            valve_en <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef ZONE_SEQ_MANUAL_EN
            man      <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            zone     <= zone_n;
            sel      <= sel_d;
            valve_en <= ven_d;
            busy     <= busy_d;
            done     <= done_d;
`ifdef ZONE_SEQ_MANUAL_EN
            man      <= man_n;
`endif
        end
    end

    // Next-state and next-zone selection; abort beats timer expiry
    always_comb begin
        state_n = state;
        zone_n  = zone;
`ifdef ZONE_SEQ_MANUAL_EN
        man_n   = man;
`endif
        unique case (state)
            IDLE: begin
                if (start && !rain) begin
                    state_n = SCAN;
                    zone_n  = FIRST_ZONE;
`ifdef ZONE_SEQ_MANUAL_EN
                    man_n   = 1'b0;
                end else if (!rain && manual_req
                             && zone_ok(manual_zone)) begin
                    state_n = WATER;
                    zone_n  = manual_zone;
                    man_n   = 1'b1;
`endif
                end
            end
            SCAN: begin
                if (abort) begin
                    state_n = DONE;
                end else if (soil_dry[zone - 3'd1]) begin
                    state_n = WATER;
                end else if (zone == LAST_ZONE) begin
                    state_n = DONE;
                end else begin
                    zone_n  = zone + 3'd1;
                end
            end
            WATER: begin
                if (abort) begin
                    state_n = DONE;
                end else if (expire) begin
`ifdef ZONE_SEQ_MANUAL_EN
                    state_n = man ? DONE : GAP;
`else
                    state_n = GAP;
`endif
                end
            end
            GAP: begin
                if (abort) begin
                    state_n = DONE;
                end else if (expire) begin
                    if (zone == LAST_ZONE) begin
                        state_n = DONE;
                    end else begin
                        state_n = SCAN;
                        zone_n  = zone + 3'd1;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Output values for the state being entered
    always_comb begin
        sel_d  = '0;
        ven_d  = 1'b0;
        busy_d = (state_n != IDLE);
        done_d = (state_n == DONE);
        if (state_n == WATER) begin
            sel_d = zone_n;
            ven_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_zone_sequencer.sv
// Directed bench for zone_sequencer (ZONE_TICKS=3, GAP_TICKS=1).
// Tick is raised every 4th clock; checks use immediate assertions.
module tb_zone_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       rain;
    logic       tick;
    logic [5:0] soil_dry;
    logic [2:0] sel;
    logic       valve_en;
    logic       busy;
    logic       done;
`ifdef ZONE_SEQ_MANUAL_EN
    logic       manual_req;
    logic [2:0] manual_zone;
`endif

    int          n_chk;
    int          n_fail;
    int          phase;
    int          wt[8];
    int          dones;
    int          bad;
    int          ven_cnt;
    int          gticks;
    int          seq_n;
    logic [31:0] seq_v;
    logic        pv;
    logic [2:0]  psel;
    bit          seen_v;
    bit          to;

    always #5 clk = ~clk;

    zone_sequencer #(
        .ZONE_TICKS (3),
        .GAP_TICKS  (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .rain        (rain),
        .tick        (tick),
        .soil_dry    (soil_dry),
`ifdef ZONE_SEQ_MANUAL_EN
        .manual_req  (manual_req),
        .manual_zone (manual_zone),
`endif
        .sel         (sel),
        .valve_en    (valve_en),
        .busy        (busy),
        .done        (done)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_stats();
        for (int i = 0; i < 8; i++) wt[i] = 0;
        dones   = 0;
        bad     = 0;
        ven_cnt = 0;
        gticks  = 0;
        seq_n   = 0;
        seq_v   = '0;
        pv      = 1'b0;
        psel    = '0;
        seen_v  = 1'b0;
    endtask

    // Observe outputs, then advance one clock and update tick
    task automatic cyc();
        if (valve_en && !pv) begin
            seq_v  = {seq_v[27:0], 1'b0, sel};
            seq_n++;
            seen_v = 1'b1;
        end
        if (valve_en) ven_cnt++;
        if (valve_en && tick) wt[sel]++;
        if (seen_v && busy && !valve_en && !done && tick) gticks++;
        if (valve_en !== (sel != 3'd0)) bad++;
        if (pv && valve_en && sel != psel) bad++;
        if (done) dones++;
        pv   = valve_en;
        psel = sel;
        @(posedge clk);
        #1;
        phase++;
        tick = (phase % 4 == 0);
    endtask

    task automatic wait_idle(input int budget, output bit tmo);
        tmo = 1'b1;
        for (int i = 0; i < budget; i++) begin
            cyc();
            if (!busy) begin
                tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_sel(input logic [2:0] z,
                            input int budget,
                            output bit tmo);
        tmo = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (valve_en && sel == z) begin
                tmo = 1'b0;
                break;
            end
            cyc();
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        phase    = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        rain     = 1'b0;
        tick     = 1'b0;
        soil_dry = '0;
`ifdef ZONE_SEQ_MANUAL_EN
        manual_req  = 1'b0;
        manual_zone = '0;
`endif
        clr_stats();

        // reset state
        cyc();
        cyc();
        chk("rst_sel", 32'(sel), 0);
        chk("rst_ven", 32'(valve_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        rst_n = 1'b1;
        cyc();

        // full cycle over all six zones
        soil_dry = 6'b111111;
        clr_stats();
        pulse_start();
        chk("full_scan_busy", 32'(busy), 1);
        chk("full_scan_ven", 32'(valve_en), 0);
        cyc();
        chk("full_z1_ven", 32'(valve_en), 1);
        chk("full_z1_sel", 32'(sel), 1);
        wait_idle(400, to);
        chk("full_timeout", 32'(to), 0);
        chk("full_seq_n", 32'(seq_n), 6);
        chk("full_seq", seq_v, 32'h0012_3456);
        for (int z = 1; z <= 6; z++)
            chk($sformatf("full_ticks_z%0d", z), 32'(wt[z]), 3);
        chk("full_gap_ticks", 32'(gticks), 6);
        chk("full_dones", 32'(dones), 1);
        chk("full_bad", 32'(bad), 0);
        chk("full_busy_end", 32'(busy), 0);

        // skip zones that are already wet
        soil_dry = 6'b010010;
        clr_stats();
        pulse_start();
        cyc();
        chk("skip_z1_ven", 32'(valve_en), 0);
        chk("skip_z1_busy", 32'(busy), 1);
        cyc();
        chk("skip_z2_ven", 32'(valve_en), 1);
        chk("skip_z2_sel", 32'(sel), 2);
        wait_idle(300, to);
        chk("skip_timeout", 32'(to), 0);
        chk("skip_seq_n", 32'(seq_n), 2);
        chk("skip_seq", seq_v, 32'h0000_0025);
        chk("skip_ticks_z2", 32'(wt[2]), 3);
        chk("skip_ticks_z5", 32'(wt[5]), 3);
        chk("skip_ticks_dry",
            32'(wt[1] + wt[3] + wt[4] + wt[6]), 0);
        chk("skip_dones", 32'(dones), 1);
        chk("skip_bad", 32'(bad), 0);

        // rain abort during zone 3
        soil_dry = 6'b111111;
        clr_stats();
        pulse_start();
        wait_sel(3'd3, 200, to);
        chk("rain_reach_z3", 32'(to), 0);
        rain = 1'b1;
        cyc();
        chk("rain_ven", 32'(valve_en), 0);
        chk("rain_sel", 32'(sel), 0);
        chk("rain_done", 32'(done), 1);
        start = 1'b1;
        cyc();
        chk("rain_idle", 32'(busy), 0);
        chk("rain_done_once", 32'(done), 0);
        cyc();
        cyc();
        chk("rain_start_ign", 32'(busy), 0);
        start = 1'b0;
        rain  = 1'b0;
        cyc();
        chk("rain_dones", 32'(dones), 1);
        chk("rain_bad", 32'(bad), 0);

        // stop wins over a coincident tick
        clr_stats();
        pulse_start();
        wait_sel(3'd1, 50, to);
        chk("stop_reach_z1", 32'(to), 0);
        stop = 1'b1;
        tick = 1'b1;
        cyc();
        stop = 1'b0;
        chk("stop_ven", 32'(valve_en), 0);
        chk("stop_done", 32'(done), 1);
        cyc();
        chk("stop_idle", 32'(busy), 0);

        // reset in the middle of zone 2
        clr_stats();
        pulse_start();
        wait_sel(3'd2, 100, to);
        chk("rst_reach_z2", 32'(to), 0);
        rst_n = 1'b0;
        cyc();
        chk("mid_rst_sel", 32'(sel), 0);
        chk("mid_rst_ven", 32'(valve_en), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        rst_n = 1'b1;
        repeat (5) cyc();
        chk("mid_rst_nodone", 32'(dones), 0);
        chk("mid_rst_idle", 32'(busy), 0);

        // nothing dry: six scan clocks then done
        soil_dry = 6'b000000;
        clr_stats();
        pulse_start();
        repeat (5) cyc();
        chk("dry0_busy", 32'(busy), 1);
        chk("dry0_early_done", 32'(done), 0);
        cyc();
        chk("dry0_done", 32'(done), 1);
        cyc();
        chk("dry0_idle", 32'(busy), 0);
        chk("dry0_no_valve", 32'(ven_cnt), 0);

        // start held while busy runs one cycle only
        clr_stats();
        start = 1'b1;
        repeat (5) cyc();
        start = 1'b0;
        wait_idle(50, to);
        chk("hold_timeout", 32'(to), 0);
        chk("hold_dones", 32'(dones), 1);
        cyc();
        chk("hold_idle", 32'(busy), 0);

`ifdef ZONE_SEQ_MANUAL_EN
        // manual watering of zone 4, no gap
        clr_stats();
        manual_zone = 3'd4;
        manual_req  = 1'b1;
        cyc();
        manual_req  = 1'b0;
        chk("man_ven", 32'(valve_en), 1);
        chk("man_sel", 32'(sel), 4);
        wait_idle(100, to);
        chk("man_timeout", 32'(to), 0);
        chk("man_ticks", 32'(wt[4]), 3);
        chk("man_seq", seq_v, 32'h0000_0004);
        chk("man_no_gap", 32'(gticks), 0);
        chk("man_dones", 32'(dones), 1);

        // out-of-range manual zone is ignored
        manual_zone = 3'd7;
        manual_req  = 1'b1;
        repeat (3) cyc();
        chk("man7_busy", 32'(busy), 0);
        chk("man7_ven", 32'(valve_en), 0);
        manual_req  = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
